dnn_stream_loader: RTL and testbench
====================================

Name: dnn_stream_loader

Overview:
- Upstream feeder for the two-layer 4-4-2 DNN datapath.
- Receives one 5-bit signed word stream over a valid/ready handshake and unpacks it into the 24 weight links and the 4 inputs x0..x3.
- Pulses in_ready once per completed input sample.
- Drains the downstream 3-cycle pipeline before any weight reload, so weights never change under a sample that is still in flight.

Parameters:
- DW, 5, word width of data, weights and inputs (signed).
- NW, 24, number of weight words per weight load.
- NX, 4, number of input words per sample.
- DRAIN, 3, downstream pipeline depth in cycles (in_ready to outNN_ready).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  DW  signed stream word.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader accepts a word this cycle.
- reload_w  in  1  single-cycle request to reload all weights.
- w04,w05,w06,w07  out  DW each  weights from x0 to hidden nodes 4..7.
- w14,w15,w16,w17  out  DW each  weights from x1 to hidden nodes 4..7.
- w24,w25,w26,w27  out  DW each  weights from x2 to hidden nodes 4..7.
- w34,w35,w36,w37  out  DW each  weights from x3 to hidden nodes 4..7.
- w48,w58,w68,w78  out  DW each  weights from hidden nodes to output 0.
- w49,w59,w69,w79  out  DW each  weights from hidden nodes to output 1.
- x0,x1,x2,x3  out  DW each  current sample inputs.
- in_ready  out  1  single-cycle pulse: x0..x3 hold a new sample.
- weights_valid  out  1  a full weight set is loaded.

Behaviour:
- Reset (async, any state): all w*, x*, in_ready and weights_valid go to 0. idx=0, reload_pend=0, state=LOAD_W.
- Handshake: a word is accepted on a rising edge where s_valid and s_ready are both 1. s_ready is a registered-state decode: 1 in LOAD_W and LOAD_X, 0 in DRAIN.
- LOAD_W:
  - Accepted word idx is written to the weight register in this order: w04,w05,w06,w07,w14..w17,w24..w27,w34..w37,w48,w58,w68,w78,w49,w59,w69,w79.
  - idx increments by 1 per accepted word.
  - When the word at idx=NW-1 is accepted: weights_valid<=1, idx<=0, state<=LOAD_X.
  - s_valid gaps stall the load without penalty.
  - reload_w is ignored in this state.
- LOAD_X:
  - Words idx 0..2 are written to shadow registers xs0..xs2.
  - When word idx=3 is accepted, on that edge: x0<=xs0, x1<=xs1, x2<=xs2, x3<=s_data, in_ready<=1, idx<=0.
  - in_ready is 1 for exactly the following cycle, then 0.
  - x0..x3 hold their values until the next completed sample. A partial sample never disturbs x outputs.
  - Back-to-back: s_ready stays 1 during the in_ready cycle. Full throughput is one sample per 4 cycles.
- reload_w handling:
  - Sampled every cycle into reload_pend (set-only, sticky).
  - reload_pend is acted on in LOAD_X only when idx=0 and no word is accepted that cycle: state<=DRAIN, drain count<=0, reload_pend<=0.
  - If reload_w arrives mid-sample (idx 1..3), the sample completes normally first (in_ready still pulses). The reload takes effect at the next idx=0 opportunity.
  - A reload_w coincident with a sample's first word (idx=0, word accepted) counts as mid-sample: the word is accepted and the reload is pended.
- DRAIN:
  - s_ready=0; counter runs for DRAIN cycles.
  - On the last cycle: weights_valid<=0, idx<=0, state<=LOAD_W.
  - Weight registers keep old values until overwritten.
  - x0..x3 are unchanged.
  - in_ready is never asserted in DRAIN or LOAD_W.
- Width rules: pure storage, no arithmetic; sign preserved bit-for-bit. idx is 5 bits and wraps only via the explicit clears above; it never exceeds NW-1.

Test Plan:
- Reset: assert rst mid-stream -> all outputs 0, s_ready=1 on the first cycle after rst falls, weights_valid=0.
- Weight load: stream values 1..24 with s_valid gaps every 3rd cycle -> w04=1, w07=4, w37=16, w78=20, w79=24; weights_valid rises the cycle after the 24th accept; no in_ready pulse.
- Sample: stream -16,15,-1,7 -> one-cycle in_ready the cycle after the 4th accept; x0=-16, x1=15, x2=-1, x3=7; values held through 20 idle cycles.
- Back-to-back: 3 samples with s_valid held high -> in_ready pulses exactly every 4 cycles; x values change only on pulse edges.
- Mid-sample reload: pulse reload_w after the 2nd word of a sample -> sample completes with in_ready; s_ready=0 for exactly 3 cycles; weights_valid falls; the next 24 words reload the weights.
- Reset during DRAIN or LOAD_W at idx=10 -> state LOAD_W, idx 0, all weights 0; a full reload is then required before any in_ready.

Source files
------------

// File: rtl/dnn_stream_loader.sv
// Stream unpacker feeding the 4-4-2 DNN datapath: loads 24 weights, then
// repeatedly loads 4-word input samples, draining the downstream pipeline before reloads.
module dnn_stream_loader #(
    parameter int DW    = 5,
    parameter int NW    = 24,
    parameter int NX    = 4,
    parameter int DRAIN = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          reload_w,
    output logic [DW-1:0] w04, w05, w06, w07,
    output logic [DW-1:0] w14, w15, w16, w17,
    output logic [DW-1:0] w24, w25, w26, w27,
    output logic [DW-1:0] w34, w35, w36, w37,
    output logic [DW-1:0] w48, w58, w68, w78,
    output logic [DW-1:0] w49, w59, w69, w79,
    output logic [DW-1:0] x0, x1, x2, x3,
    output logic          in_ready,
    output logic          weights_valid
);

    localparam int CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic [1:0] {ST_LOAD_W, ST_LOAD_X, ST_DRAIN} state_t;

    state_t          state, state_n;
    logic [4:0]      idx, idx_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            reload_pend, pend_n;
    logic            wv_n, ir_n;
    logic            accept, w_we, xs_we, x_we;

    logic [DW-1:0]   wreg [0:NW-1];
    logic [DW-1:0]   xs   [0:NX-2];

    assign s_ready = (state != ST_DRAIN);
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_LOAD_W;
            idx           <= '0;
            cnt           <= '0;
            reload_pend   <= 1'b0;
            weights_valid <= 1'b0;
            in_ready      <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            cnt           <= cnt_n;
            reload_pend   <= pend_n;
            weights_valid <= wv_n;
            in_ready      <= ir_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        // reload requests only register while streaming samples
        pend_n  = reload_pend | (reload_w && (state == ST_LOAD_X));
        wv_n    = weights_valid;
        ir_n    = 1'b0;
        w_we    = 1'b0;
        xs_we   = 1'b0;
        x_we    = 1'b0;
        case (state)
            ST_LOAD_W: begin
                if (accept) begin
                    w_we = 1'b1;
                    if (idx == 5'(NW - 1)) begin
                        wv_n    = 1'b1;
                        idx_n   = '0;
                        state_n = ST_LOAD_X;
                    end else begin
                        idx_n = idx + 5'd1;
                    end
                end
            end
            ST_LOAD_X: begin
                if (accept) begin
                    if (idx == 5'(NX - 1)) begin
                        x_we  = 1'b1;
                        ir_n  = 1'b1;
                        idx_n = '0;
                    end else begin
                        xs_we = 1'b1;
                        idx_n = idx + 5'd1;
                    end
                end else if (idx == '0 && reload_pend) begin
                    state_n = ST_DRAIN;
                    cnt_n   = '0;
                    pend_n  = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (cnt == CW'(DRAIN - 1)) begin
                    wv_n    = 1'b0;
                    idx_n   = '0;
                    state_n = ST_LOAD_W;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_LOAD_W;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NW; i++) wreg[i] <= '0;
            for (int unsigned i = 0; i < NX - 1; i++) xs[i] <= '0;
            x0 <= '0;
            x1 <= '0;
            x2 <= '0;
            x3 <= '0;
        end else begin
            if (w_we)  wreg[idx] <= s_data;
            if (xs_we) xs[idx[1:0]] <= s_data;
            // outputs update atomically so a partial sample is never visible
            if (x_we) begin
                x0 <= xs[0];
                x1 <= xs[1];
                x2 <= xs[2];
                x3 <= s_data;
            end
        end
    end

    assign {w04, w05, w06, w07} = {wreg[0],  wreg[1],  wreg[2],  wreg[3]};
    assign {w14, w15, w16, w17} = {wreg[4],  wreg[5],  wreg[6],  wreg[7]};
    assign {w24, w25, w26, w27} = {wreg[8],  wreg[9],  wreg[10], wreg[11]};
    assign {w34, w35, w36, w37} = {wreg[12], wreg[13], wreg[14], wreg[15]};
    assign {w48, w58, w68, w78} = {wreg[16], wreg[17], wreg[18], wreg[19]};
    assign {w49, w59, w69, w79} = {wreg[20], wreg[21], wreg[22], wreg[23]};

endmodule

// File: tb/tb_dnn_stream_loader.sv
// Directed bench for dnn_stream_loader: reset, weight load, samples,
// back-to-back throughput, mid-sample reload and reset during reload.
module tb_dnn_stream_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       reload_w = 1'b0;
    logic       s_ready, in_ready, weights_valid;
    logic [4:0] w04, w05, w06, w07, w14, w15, w16, w17, w24, w25, w26, w27;
    logic [4:0] w34, w35, w36, w37, w48, w58, w68, w78, w49, w59, w69, w79;
    logic [4:0] x0, x1, x2, x3;
    logic [119:0] all_w;
    logic [19:0]  all_x;

    int checks = 0;
    int errors = 0;

    dnn_stream_loader #(.DW(5), .NW(24), .NX(4), .DRAIN(3)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .reload_w(reload_w),
        .w04(w04), .w05(w05), .w06(w06), .w07(w07),
        .w14(w14), .w15(w15), .w16(w16), .w17(w17),
        .w24(w24), .w25(w25), .w26(w26), .w27(w27),
        .w34(w34), .w35(w35), .w36(w36), .w37(w37),
        .w48(w48), .w58(w58), .w68(w68), .w78(w78),
        .w49(w49), .w59(w59), .w69(w69), .w79(w79),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .in_ready(in_ready), .weights_valid(weights_valid)
    );

    assign all_w = {w04, w05, w06, w07, w14, w15, w16, w17, w24, w25, w26, w27,
                    w34, w35, w36, w37, w48, w58, w68, w78, w49, w59, w69, w79};
    assign all_x = {x0, x1, x2, x3};

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [4:0] d);
        s_valid = 1'b1;
        s_data  = d;
        cyc();
    endtask

    task automatic test_reset();
        cyc(); cyc();
        rst = 1'b0;
        send_word(5'd1); send_word(5'd2); send_word(5'd3);
        rst = 1'b1;
        #1;
        checks++; if (all_w !== '0) begin errors++; $display("FAIL reset_w got %h want 0", all_w); end
        checks++; if (all_x !== '0) begin errors++; $display("FAIL reset_x got %h want 0", all_x); end
        checks++; if (weights_valid !== 1'b0) begin errors++; $display("FAIL reset_wv got %b want 0", weights_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ir got %b want 0", in_ready); end
        s_valid = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_sready got %b want 1", s_ready); end
        checks++; if (weights_valid !== 1'b0) begin errors++; $display("FAIL reset_wv_after got %b want 0", weights_valid); end
    endtask

    task automatic test_weight_load();
        int k = 1;
        int c = 0;
        while (k <= 24) begin
            if (c % 3 == 2) s_valid = 1'b0;
            else begin s_valid = 1'b1; s_data = 5'(k); end
            cyc();
            if (s_valid) begin
                if (k == 23) begin
                    checks++; if (weights_valid !== 1'b0) begin errors++; $display("FAIL wload_wv_early got %b want 0", weights_valid); end
                end
                k++;
            end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wload_ir got %b want 0", in_ready); end
            c++;
        end
        s_valid = 1'b0;
        checks++; if (weights_valid !== 1'b1) begin errors++; $display("FAIL wload_wv got %b want 1", weights_valid); end
        checks++; if (w04 !== 5'd1) begin errors++; $display("FAIL wload_w04 got %0d want 1", w04); end
        checks++; if (w07 !== 5'd4) begin errors++; $display("FAIL wload_w07 got %0d want 4", w07); end
        checks++; if (w37 !== 5'd16) begin errors++; $display("FAIL wload_w37 got %0d want 16", w37); end
        checks++; if (w78 !== 5'd20) begin errors++; $display("FAIL wload_w78 got %0d want 20", w78); end
        checks++; if (w79 !== 5'd24) begin errors++; $display("FAIL wload_w79 got %0d want 24", w79); end
    endtask

    task automatic test_sample();
        send_word(5'h10); send_word(5'h0F); send_word(5'h1F);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sample_ir_early got %b want 0", in_ready); end
        checks++; if (all_x !== '0) begin errors++; $display("FAIL sample_partial got %h want 0", all_x); end
        send_word(5'h07);
        s_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sample_ir got %b want 1", in_ready); end
        checks++; if (all_x !== {5'h10, 5'h0F, 5'h1F, 5'h07}) begin errors++; $display("FAIL sample_x got %h want %h", all_x, {5'h10, 5'h0F, 5'h1F, 5'h07}); end
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sample_ir_idle got %b want 0", in_ready); end
        end
        checks++; if (all_x !== {5'h10, 5'h0F, 5'h1F, 5'h07}) begin errors++; $display("FAIL sample_hold got %h want %h", all_x, {5'h10, 5'h0F, 5'h1F, 5'h07}); end
    endtask

    task automatic test_back_to_back();
        logic       exp_ir;
        logic [4:0] exp_x0, exp_x3;
        for (int k = 1; k <= 12; k++) begin
            send_word(5'(k));
            exp_ir = (k % 4 == 0);
            exp_x0 = (k / 4 == 0) ? 5'h10 : 5'((k / 4 - 1) * 4 + 1);
            exp_x3 = (k / 4 == 0) ? 5'h07 : 5'((k / 4 - 1) * 4 + 4);
            checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL b2b_ir k=%0d got %b want %b", k, in_ready, exp_ir); end
            checks++; if (x0 !== exp_x0) begin errors++; $display("FAIL b2b_x0 k=%0d got %h want %h", k, x0, exp_x0); end
            checks++; if (x3 !== exp_x3) begin errors++; $display("FAIL b2b_x3 k=%0d got %h want %h", k, x3, exp_x3); end
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_sready k=%0d got %b want 1", k, s_ready); end
        end
        s_valid = 1'b0;
        cyc();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ir_end got %b want 0", in_ready); end
    endtask

    task automatic test_mid_reload();
        send_word(5'd3); send_word(5'h1D);
        reload_w = 1'b1;
        send_word(5'd9);
        reload_w = 1'b0;
        send_word(5'h17);
        s_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ir got %b want 1", in_ready); end
        checks++; if (all_x !== {5'd3, 5'h1D, 5'd9, 5'h17}) begin errors++; $display("FAIL mid_x got %h want %h", all_x, {5'd3, 5'h1D, 5'd9, 5'h17}); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL mid_sready_ir got %b want 1", s_ready); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_drain%0d got %b want 0", i, s_ready); end
            checks++; if (weights_valid !== 1'b1) begin errors++; $display("FAIL mid_wv_drain%0d got %b want 1", i, weights_valid); end
        end
        cyc();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL mid_sready_after got %b want 1", s_ready); end
        checks++; if (weights_valid !== 1'b0) begin errors++; $display("FAIL mid_wv_fall got %b want 0", weights_valid); end
        checks++; if (w04 !== 5'd1) begin errors++; $display("FAIL mid_w_kept got %0d want 1", w04); end
        for (int i = 0; i < 24; i++) begin
            send_word(5'(24 - i));
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reload_ir got %b want 0", in_ready); end
        end
        s_valid = 1'b0;
        checks++; if (weights_valid !== 1'b1) begin errors++; $display("FAIL mid_reload_wv got %b want 1", weights_valid); end
        checks++; if (w04 !== 5'd24) begin errors++; $display("FAIL mid_reload_w04 got %0d want 24", w04); end
        checks++; if (w37 !== 5'd9) begin errors++; $display("FAIL mid_reload_w37 got %0d want 9", w37); end
        checks++; if (w79 !== 5'd1) begin errors++; $display("FAIL mid_reload_w79 got %0d want 1", w79); end
        checks++; if (x0 !== 5'd3) begin errors++; $display("FAIL mid_x_kept got %0d want 3", x0); end
    endtask

    task automatic test_reset_load_w();
        reload_w = 1'b1;
        cyc();
        reload_w = 1'b0;
        cyc();
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rlw_drain got %b want 0", s_ready); end
        cyc(); cyc(); cyc();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rlw_loadw got %b want 1", s_ready); end
        for (int i = 0; i < 10; i++) send_word(5'd5);
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (all_w !== '0) begin errors++; $display("FAIL rlw_w got %h want 0", all_w); end
        checks++; if (all_x !== '0) begin errors++; $display("FAIL rlw_x got %h want 0", all_x); end
        checks++; if (weights_valid !== 1'b0) begin errors++; $display("FAIL rlw_wv got %b want 0", weights_valid); end
        cyc();
        rst = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            send_word(5'd7);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rlw_ir got %b want 0", in_ready); end
        end
        s_valid = 1'b0;
        cyc();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rlw_ir_end got %b want 0", in_ready); end
        checks++; if (w04 !== 5'd7 || w07 !== 5'd7 || w14 !== 5'd0) begin errors++; $display("FAIL rlw_wload got %0d/%0d/%0d want 7/7/0", w04, w07, w14); end
        checks++; if (weights_valid !== 1'b0) begin errors++; $display("FAIL rlw_wv_end got %b want 0", weights_valid); end
    endtask

    initial begin
        test_reset();
        test_weight_load();
        test_sample();
        test_back_to_back();
        test_mid_reload();
        test_reset_load_w();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
